// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: pattern modes and bounce direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Divides clk into a one-cycle step tick every DIV enabled cycles; count holds while paused.
module led_prescaler #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  // NOTE: state registers use non-blocking assignments and reset asynchronously so the
  // reset value appears without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: advances an N-bit rotate/bounce/Johnson pattern on each
// prescaler tick, or on a manual step while paused.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N   = 16,
  parameter int DIV = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         step,
  output logic [N-1:0] led,
  output logic         tick_o
);

  localparam logic [N-1:0] LED_INIT = N'(1);

  logic         pre_tick;
  logic         adv;
  dir_e         dir, dir_n;
  mode_e        mode_q, mode_n;
  logic [N-1:0] led_n;

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (pre_tick)
  );

  assign adv = pre_tick | (step & ~en);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    led_n  = led;
    dir_n  = dir;
    mode_n = mode_q;
    if (mode_e'(mode) != mode_q) begin
      // A mode change always reloads, so no mode ever sees another mode's leftovers.
      led_n  = LED_INIT;
      dir_n  = DIR_LEFT;
      mode_n = mode_e'(mode);
    end else begin
      case (mode_q)
        MODE_ROT_L: led_n = {led[N-2:0], led[N-1]};
        MODE_ROT_R: led_n = {led[0], led[N-1:1]};
        MODE_BOUNCE: begin
          if (dir == DIR_LEFT && led[N-1]) begin
            dir_n = DIR_RIGHT;
            led_n = led >> 1;
          end else if (dir == DIR_RIGHT && led[0]) begin
            dir_n = DIR_LEFT;
            led_n = led << 1;
          end else begin
            led_n = (dir == DIR_LEFT) ? (led << 1) : (led >> 1);
          end
        end
        MODE_FILL: led_n = {led[N-2:0], ~led[N-1]};
        default: led_n = LED_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led    <= LED_INIT;
      dir    <= DIR_LEFT;
      mode_q <= MODE_ROT_L;
      tick_o <= 1'b0;
    end else begin
      tick_o <= adv;
      if (adv) begin
        led    <= led_n;
        dir    <= dir_n;
        mode_q <= mode_n;
      end
    end
  end

endmodule
